tia_horizontal_lfsr_encoder: RTL and testbench
==============================================

# tia_horizontal_lfsr_encoder

Converts a binary horizontal count (0..56) into the 6-bit TIA horizontal LFSR pattern that the horizontal counter presents at that count. It is the inverse of the horizontal LFSR decoder path. Test benches and the scheduler use it to derive compare patterns (SHS, RHS, RCB, RHB, LRHB, CNT) from cycle numbers instead of hand-coding LFSR constants. The default build steps a private LFSR model iteratively; an optional ROM build answers in one cycle.

## Interface
Parameters:
- none; LFSR width (6) and period (57) are fixed by the TIA.

Ports:
- clk  in  1  system clock, all state on rising edge
- rstl  in  1  asynchronous active-low reset
- req  in  1  request; sampled only when busy=0
- target  in  6  binary horizontal count, legal 0..56
- busy  out  1  conversion in progress; req ignored while high
- valid  out  1  one-cycle pulse: pattern/err updated this cycle
- pattern  out  6  LFSR pattern, bit5..bit0; held until next valid
- err  out  1  last request out of range; held until next valid

## Operation
- LFSR model:
  - Reset state 000000.
  - Next state = {~(s[0]^s[1]), s[5:1]} (shift right, XNOR feedback into bit5).
- Count n maps to the state reached after n steps from 000000. Count 56 = 010100, which the real counter wraps to 000000. Count 57 is never produced.
- States: IDLE, STEP, DONE.
- IDLE:
  - busy=0.
  - On req=1, capture target into tgt.
  - If tgt>56: go to DONE with err_next=1, pattern_next=000000.
  - Otherwise: go to STEP, cnt=0, lfsr=000000.
- STEP:
  - busy=1.
  - Each edge: if cnt==tgt, latch pattern_next=lfsr, err_next=0, go to DONE. Otherwise cnt=cnt+1 and lfsr=next(lfsr).
- DONE:
  - busy=1, valid=1 for exactly one cycle.
  - pattern/err take the latched values on entry.
  - Next edge returns to IDLE.
- Counters:
  - cnt is 6-bit unsigned and never exceeds 56.
  - The range compare is unsigned, so targets 57..63 are errors.
- req held high: a new request is captured on the first IDLE cycle after DONE. Back-to-back conversions are legal with one IDLE cycle between them.
- target is sampled only at capture. Changes while busy have no effect.
- Reset: asynchronous assertion at any point, including mid-STEP, aborts the conversion. The block returns to IDLE and the following outputs apply:

## Timing
- Reset values: busy=0, valid=0, pattern=000000, err=0, state=IDLE.
- While rstl=0, req is ignored. The first capture can happen on the first clk edge with rstl=1.
- Let E0 be the capture edge. Iterative build:
  - Legal target t: valid is high in the cycle after edge E0+t+1, i.e. t+2 edges after capture. t=0 gives 2; t=56 gives 58.
  - Illegal target: valid after E0+1 (1 edge).
- busy rises after E0 and falls after the edge that leaves DONE.
- valid and busy are both high during the DONE cycle.
- pattern and err are registered outputs that change only on the edge entering DONE.

## Configuration
- TIA_HLFSR_ENCODER_ROM_EN:
  - Defined: STEP is not built. A 57-entry constant table generated from the same LFSR rule maps target to pattern. Every request, legal or illegal, goes IDLE→DONE, with valid one edge after capture (latency 1).
  - Undefined: iterative stepping as above.
- pattern and err values must be identical in both builds. Only latency differs.

## Test plan
- Reset with rstl=0 for 3 cycles, then release → busy=0, valid=0, pattern=000000, err=0; req during reset is not captured.
- req with target=0, 4, 8, 16 → pattern=000000, 111100, 110111, 011100, err=0. valid arrives 2, 6, 10, 18 edges after capture (1 edge with ROM).
- req with target=18, 36, 56 → pattern=010111, 101100, 010100. Sweeping 0..56 must match a reference LFSR model at every count, with no duplicate patterns.
- req with target=57 and 63 → err=1, pattern=000000, valid 1 edge after capture. A following legal target=4 returns err=0, pattern=111100.
- req held high with target=36 changed to 4 while busy → result 101100 only. Next capture (target=4) occurs on the IDLE cycle after DONE.
- Assert rstl at cycle 20 of a target=56 conversion → all outputs 0 immediately, no valid pulse. A request after release completes normally.

Source files
------------

// File: rtl/tia_horizontal_lfsr_encoder.sv
// rtl/tia_horizontal_lfsr_encoder.sv - binary horizontal count (0..56) to TIA 6-bit horizontal LFSR pattern
// Optional build: TIA_HLFSR_ENCODER_ROM_EN selects a one-cycle table lookup instead of iterative stepping.
module tia_horizontal_lfsr_encoder (
  input  logic       clk,
  input  logic       rstl,
  input  logic       req,
  input  logic [5:0] target,
  output logic       busy,
  output logic       valid,
  output logic [5:0] pattern,
  output logic       err
);

  localparam logic [5:0] LAST_COUNT = 6'd56;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  // Horizontal counter rule: shift right, XNOR of the two low bits feeds bit5.
  function automatic logic [5:0] lfsr_next(input logic [5:0] s);
    return {~(s[0] ^ s[1]), s[5:1]};
  endfunction

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic [5:0] pattern_q, pattern_d;
  logic       err_q, err_d;

`ifdef TIA_HLFSR_ENCODER_ROM_EN
  // Table entry i holds the state reached after i steps from 000000.
  function automatic logic [6*57-1:0] build_rom();
    logic [6*57-1:0] r;
    logic [5:0]      s;
    r = '0;
    s = '0;
    for (int i = 0; i < 57; i++) begin
      r[i*6 +: 6] = s;
      s = lfsr_next(s);
    end
    return r;
  endfunction

  localparam logic [6*57-1:0] ROM = build_rom();

  logic [8:0] rom_idx;
  logic [5:0] rom_pattern;

  // Out-of-range targets index entry 0; their result is forced by the error path anyway.
  always_comb begin
    rom_idx     = (target > LAST_COUNT) ? 9'd0 : ({3'b000, target} * 9'd6);
    rom_pattern = ROM[rom_idx +: 6];
  end
`else
  logic [5:0] tgt_q, tgt_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] lfsr_q, lfsr_d;
`endif

  // Next-state and registered-output logic; outputs are computed from the state being entered.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    pattern_d = pattern_q;
    err_d     = err_q;
`ifndef TIA_HLFSR_ENCODER_ROM_EN
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          busy_d = 1'b1;
          if (target > LAST_COUNT) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            err_d     = 1'b1;
            pattern_d = 6'b000000;
          end else begin
`ifdef TIA_HLFSR_ENCODER_ROM_EN
            state_d   = DONE;
            valid_d   = 1'b1;
            err_d     = 1'b0;
            pattern_d = rom_pattern;
`else
            state_d   = STEP;
            tgt_d     = target;
            cnt_d     = 6'd0;
            lfsr_d    = 6'b000000;
`endif
          end
        end
      end
`ifndef TIA_HLFSR_ENCODER_ROM_EN
      STEP: begin
        if (cnt_q == tgt_q) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          err_d     = 1'b0;
          pattern_d = lfsr_q;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          lfsr_d = lfsr_next(lfsr_q);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pattern_q <= 6'b000000;
      err_q     <= 1'b0;
`ifndef TIA_HLFSR_ENCODER_ROM_EN
      tgt_q     <= 6'd0;
      cnt_q     <= 6'd0;
      lfsr_q    <= 6'b000000;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pattern_q <= pattern_d;
      err_q     <= err_d;
`ifndef TIA_HLFSR_ENCODER_ROM_EN
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign pattern = pattern_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tia_horizontal_lfsr_encoder.sv
// tb/tb_tia_horizontal_lfsr_encoder.sv - directed table bench for tia_horizontal_lfsr_encoder
module tb_tia_horizontal_lfsr_encoder;

  logic       clk;
  logic       rstl;
  logic       req;
  logic [5:0] target;
  logic       busy;
  logic       valid;
  logic [5:0] pattern;
  logic       err;

  int n_cmp;
  int n_fail;

  tia_horizontal_lfsr_encoder dut (
    .clk     (clk),
    .rstl    (rstl),
    .req     (req),
    .target  (target),
    .busy    (busy),
    .valid   (valid),
    .pattern (pattern),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] tgt;
    logic [5:0] exp_pattern;
    logic       exp_err;
  } vec_t;

  function automatic int exp_latency(input logic [5:0] t);
`ifdef TIA_HLFSR_ENCODER_ROM_EN
    return 1;
`else
    return (t > 6'd56) ? 1 : int'(t) + 2;
`endif
  endfunction

  function automatic logic [5:0] ref_pattern(input int n);
    logic [5:0] s;
    s = 6'b000000;
    for (int i = 0; i < n; i++) s = {~(s[0] ^ s[1]), s[5:1]};
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one request from IDLE, count edges from capture (capture edge = 1) until valid,
  // then step past DONE so the block is back in IDLE.
  task automatic do_conv(input logic [5:0] t, output logic [5:0] p, output logic e, output int lat);
    @(negedge clk);
    target = t;
    req    = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    lat = 1;
    while (!valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = pattern;
    e = err;
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[9];
  logic [5:0] p;
  logic       e;
  int         lat;
  bit         seen[64];
  int         dups;
  int         vcount;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{6'd0,  6'b000000, 1'b0};
    vecs[1] = '{6'd4,  6'b111100, 1'b0};
    vecs[2] = '{6'd8,  6'b110111, 1'b0};
    vecs[3] = '{6'd16, 6'b011100, 1'b0};
    vecs[4] = '{6'd18, 6'b010111, 1'b0};
    vecs[5] = '{6'd36, 6'b101100, 1'b0};
    vecs[6] = '{6'd56, 6'b010100, 1'b0};
    vecs[7] = '{6'd57, 6'b000000, 1'b1};
    vecs[8] = '{6'd63, 6'b000000, 1'b1};

    // Reset for 3 cycles with a request pending that must not be captured.
    rstl   = 1'b0;
    req    = 1'b1;
    target = 6'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req  = 1'b0;
    rstl = 1'b1;
    @(posedge clk);
    #1;
    check("reset_busy",    busy,    0);
    check("reset_valid",   valid,   0);
    check("reset_pattern", pattern, 0);
    check("reset_err",     err,     0);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      do_conv(vecs[i].tgt, p, e, lat);
      check($sformatf("vec%0d_pattern", vecs[i].tgt), p,   vecs[i].exp_pattern);
      check($sformatf("vec%0d_err", vecs[i].tgt),     e,   vecs[i].exp_err);
      check($sformatf("vec%0d_latency", vecs[i].tgt), lat, exp_latency(vecs[i].tgt));
    end

    // Legal request directly after an error clears err.
    do_conv(6'd4, p, e, lat);
    check("after_err_pattern", p, 6'b111100);
    check("after_err_err",     e, 0);

    // Full sweep against the reference model, with duplicate detection.
    dups = 0;
    for (int n = 0; n < 64; n++) seen[n] = 1'b0;
    for (int n = 0; n <= 56; n++) begin
      do_conv(6'(n), p, e, lat);
      check($sformatf("sweep%0d_pattern", n), p, ref_pattern(n));
      check($sformatf("sweep%0d_err", n),     e, 0);
      if (seen[p]) dups++;
      seen[p] = 1'b1;
    end
    check("sweep_duplicates", dups, 0);

    // req held high; target changes while busy must not affect the result.
    @(negedge clk);
    target = 6'd36;
    req    = 1'b1;
    @(posedge clk);
    #1;
    target = 6'd4;
    lat = 1;
    while (!valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held_first_pattern", pattern, 6'b101100);
    check("held_first_latency", lat, exp_latency(6'd36));
    @(posedge clk);
    #1;
    check("held_idle_gap_busy", busy, 0);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("held_second_capture_busy", busy, 1);
    lat = 1;
    while (!valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held_second_pattern", pattern, 6'b111100);
    check("held_second_latency", lat, exp_latency(6'd4));
    @(posedge clk);
    #1;

    // Reset asserted 20 cycles into a target=56 conversion.
    @(negedge clk);
    target = 6'd56;
    req    = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rstl = 1'b0;
    #1;
    check("midrst_busy",    busy,    0);
    check("midrst_valid",   valid,   0);
    check("midrst_pattern", pattern, 0);
    check("midrst_err",     err,     0);
    vcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    rstl = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("midrst_no_valid", vcount, 0);
    do_conv(6'd56, p, e, lat);
    check("post_rst_pattern", p,   6'b010100);
    check("post_rst_err",     e,   0);
    check("post_rst_latency", lat, exp_latency(6'd56));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
